// File: rtl/cpu_run_pkg.sv
// Shared encodings for the run-control sequencer:
// FSM states, halt causes and the halt instruction word.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_HALTED = 3'd3,
    ST_STEP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_REQ   = 2'd1,
    CAUSE_BP    = 2'd2,
    CAUSE_HWORD = 2'd3
  } cause_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear,
// used to count enabled pipeline cycles.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // clear wins; otherwise count up and stick at all ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: instruction load, run/halt,
// single-step, breakpoint and halt-word detection.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int PC_W       = 5,
  parameter int IMEM_DEPTH = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              soft_rst_req,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc_f,
  input  logic [DATA_W-1:0] instr_d,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic              imem_we,
  output logic [PC_W-1:0]   imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic              load_done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [PC_W-1:0] LAST = PC_W'(IMEM_DEPTH - 1);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [PC_W-1:0]   ptr_q, ptr_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              rstn_q, rstn_d;
  logic              halted_q, halted_d;
  logic              done_q, done_d;
  logic              skip_q, skip_d;
  logic              hword, bp_hit, stop_now, en;

  assign hword    = (instr_d == DATA_W'(HALT_WORD));
  assign bp_hit   = bp_en & ~skip_q & (pc_f == bp_addr);
  assign stop_now = hword | bp_hit | halt_req;

  // next state, load writes, halt cause and pipeline enable
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    skip_d  = skip_q;
    en      = 1'b0;
    if (soft_rst_req) begin
      state_d = ST_IDLE;
      cause_d = CAUSE_NONE;
      skip_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
          end else if (run_req) begin
            state_d = ST_RUN;
            skip_d  = 1'b0;
          end
        end
        ST_LOAD: begin
          if (halt_req) begin
            state_d = ST_IDLE;
          end else if (load_valid) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = load_data;
            if (ptr_q == LAST) state_d = ST_IDLE;
            else               ptr_d   = ptr_q + 1'b1;
          end
        end
        ST_RUN: begin
          en = ~stop_now;
          if (en) skip_d = 1'b0;
          if (stop_now) begin
            state_d = ST_HALTED;
            unique case (1'b1)
              hword:   cause_d = CAUSE_HWORD;
              bp_hit:  cause_d = CAUSE_BP;
              default: cause_d = CAUSE_REQ;
            endcase
          end
        end
        ST_HALTED: begin
          if (step_req) begin
            state_d = ST_STEP;
          end else if (run_req && cause_q != CAUSE_HWORD) begin
            state_d = ST_RUN;
            skip_d  = 1'b1;
          end else if (load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
          end
        end
        ST_STEP: begin
          en      = 1'b1;
          state_d = ST_HALTED;
          if (hword) cause_d = CAUSE_HWORD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    rstn_d   = (state_d == ST_RUN) || (state_d == ST_HALTED)
            || (state_d == ST_STEP);
    halted_d = (state_d == ST_HALTED);
    done_d   = we_q && (addr_q == LAST);
  end

  // control and output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cause_q  <= CAUSE_NONE;
      ptr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rstn_q   <= 1'b0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rstn_q   <= rstn_d;
      halted_q <= halted_d;
      done_q   <= done_d;
      skip_q   <= skip_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .en_i   (en),
    .clr_i  (soft_rst_req),
    .cnt_o  (cycle_cnt)
  );

  assign cpu_en     = en;
  assign cpu_rst_n  = rstn_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign halted     = halted_q;
  assign halt_cause = cause_q;
  assign load_done  = done_q;

endmodule
